// File: rtl/lab3_qsys_debug_ocimem_arbiter_pkg.sv
// Shared definitions for the debug monitor RAM arbiter: default widths,
// FSM state encoding and grant identifiers.
package lab3_qsys_debug_ocimem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_CPU_ACC    = 3'd1;
  localparam state_t ST_CPU_RDATA  = 3'd2;
  localparam state_t ST_JTAG_ACC   = 3'd3;
  localparam state_t ST_JTAG_RDATA = 3'd4;

  // Which requester was granted most recently; used to alternate on contention.
  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_JTAG = 1'b1;

endpackage

// File: rtl/lab3_qsys_debug_jtag_holdreg.sv
// JTAG-side holding register: captures single-cycle access pulses, keeps the
// auto-increment pointer and flags requests dropped while the register is full.
module lab3_qsys_debug_jtag_holdreg #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic              jtag_incr,
  input  logic              jtag_addr_load,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  input  logic              jtag_ovr_clr,
  input  logic              pend_clr,
  output logic              pend,
  output logic              hold_wr,
  output logic [ADDR_W-1:0] hold_addr,
  output logic [DATA_W-1:0] hold_wdata,
  output logic              overrun
);

  logic [ADDR_W-1:0] pointer;
  logic [ADDR_W-1:0] ptr_base;
  logic              accept;

  // A load in the same cycle as an incr request takes effect before the access.
  always_comb begin
    ptr_base = jtag_addr_load ? jtag_addr : pointer;
    accept   = jtag_req && (!pend || pend_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend       <= 1'b0;
      hold_wr    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      pointer    <= '0;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        pend       <= 1'b1;
        hold_wr    <= jtag_wr;
        hold_addr  <= jtag_incr ? ptr_base : jtag_addr;
        hold_wdata <= jtag_wdata;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end

      if (accept && jtag_incr)
        pointer <= ptr_base + ADDR_W'(1);
      else if (jtag_addr_load)
        pointer <= jtag_addr;

      // A drop in the same cycle as a clear leaves the flag set.
      if (jtag_req && !accept)
        overrun <= 1'b1;
      else if (jtag_ovr_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/lab3_qsys_debug_ocimem_arbiter.sv
// Shares the single-port debug monitor RAM between the JTAG holding register
// and the stallable CPU Avalon-MM slave, alternating grants on contention.
module lab3_qsys_debug_ocimem_arbiter
  import lab3_qsys_debug_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic              jtag_incr,
  input  logic              jtag_addr_load,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  input  logic              jtag_ovr_clr,
  output logic [DATA_W-1:0] mon_dreg,
  output logic              mon_ready,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state, state_nxt;
  logic              last_grant;
  logic              pend, pend_clr, hold_wr;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic              cpu_req;

  assign cpu_req   = avs_read | avs_write;
  assign jtag_busy = pend;

  lab3_qsys_debug_jtag_holdreg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_holdreg (
    .clk            (clk),
    .reset_n        (reset_n),
    .jtag_req       (jtag_req),
    .jtag_wr        (jtag_wr),
    .jtag_incr      (jtag_incr),
    .jtag_addr_load (jtag_addr_load),
    .jtag_addr      (jtag_addr),
    .jtag_wdata     (jtag_wdata),
    .jtag_ovr_clr   (jtag_ovr_clr),
    .pend_clr       (pend_clr),
    .pend           (pend),
    .hold_wr        (hold_wr),
    .hold_addr      (hold_addr),
    .hold_wdata     (hold_wdata),
    .overrun        (jtag_overrun)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned and infers a latch.
  always_comb begin
    state_nxt       = state;
    pend_clr        = 1'b0;
    ram_addr        = avs_address;
    ram_we          = 1'b0;
    ram_wdata       = avs_writedata;
    avs_waitrequest = cpu_req;
    avs_readdata    = '0;
    case (state)
      ST_IDLE: begin
        if (pend && cpu_req)
          state_nxt = (last_grant == GRANT_JTAG) ? ST_CPU_ACC : ST_JTAG_ACC;
        else if (pend)
          state_nxt = ST_JTAG_ACC;
        else if (cpu_req)
          state_nxt = ST_CPU_ACC;
      end
      ST_CPU_ACC: begin
        ram_we = avs_write;
        if (avs_write) begin
          avs_waitrequest = 1'b0;
          state_nxt       = ST_IDLE;
        end else begin
          state_nxt = avs_read ? ST_CPU_RDATA : ST_IDLE;
        end
      end
      ST_CPU_RDATA: begin
        avs_readdata    = ram_rdata;
        avs_waitrequest = 1'b0;
        state_nxt       = ST_IDLE;
      end
      ST_JTAG_ACC: begin
        ram_addr  = hold_addr;
        ram_we    = hold_wr;
        ram_wdata = hold_wdata;
        pend_clr  = hold_wr;
        state_nxt = hold_wr ? ST_IDLE : ST_JTAG_RDATA;
      end
      ST_JTAG_RDATA: begin
        ram_addr  = hold_addr;
        pend_clr  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_CPU;
      mon_ready  <= 1'b0;
      mon_dreg   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_CPU_ACC && state == ST_IDLE)
        last_grant <= GRANT_CPU;
      else if (state_nxt == ST_JTAG_ACC && state == ST_IDLE)
        last_grant <= GRANT_JTAG;
      // Completion pulse lands the cycle after the holding register empties.
      mon_ready <= pend_clr;
      if (state == ST_JTAG_RDATA)
        mon_dreg <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_lab3_qsys_debug_ocimem_arbiter.sv
// Self-checking bench: transaction-level reference memory and pointer model,
// directed scenarios followed by a randomized sequence of CPU/JTAG accesses.
module tb_lab3_qsys_debug_ocimem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          jtag_req = 1'b0, jtag_wr = 1'b0, jtag_incr = 1'b0, jtag_addr_load = 1'b0;
  logic [AW-1:0] jtag_addr = '0;
  logic [DW-1:0] jtag_wdata = '0;
  logic          jtag_ovr_clr = 1'b0;
  logic [DW-1:0] mon_dreg;
  logic          mon_ready, jtag_busy, jtag_overrun;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0, avs_write = 1'b0;
  logic [DW-1:0] avs_writedata = '0;
  logic [DW-1:0] avs_readdata;
  logic          avs_waitrequest;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  lab3_qsys_debug_ocimem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_incr(jtag_incr),
    .jtag_addr_load(jtag_addr_load), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .jtag_ovr_clr(jtag_ovr_clr),
    .mon_dreg(mon_dreg), .mon_ready(mon_ready), .jtag_busy(jtag_busy),
    .jtag_overrun(jtag_overrun),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Monitor RAM: single port, one-cycle read latency, read-before-write.
  logic [DW-1:0] mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: what the RAM should contain and where the pointer sits.
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  logic [AW-1:0] ref_ptr = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cpu(input string tag, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wdata);
    int cyc;
    avs_address = addr; avs_write = wr; avs_read = !wr; avs_writedata = wdata;
    #1;
    cyc = 1;
    while (avs_waitrequest && cyc < 40) begin tick(); cyc++; end
    check({tag, "_lat"}, cyc, wr ? 2 : 3);
    if (wr) ref_mem[addr] = wdata;
    else    check({tag, "_data"}, avs_readdata, ref_mem[addr]);
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic do_jtag(input string tag, input logic wr, input logic incr, input logic load,
                         input logic [7:0] addr, input logic [31:0] wdata);
    logic [7:0] a;
    int         cyc;
    if (incr) begin
      a = load ? addr : ref_ptr;
      ref_ptr = a + 8'd1;
    end else begin
      a = addr;
      if (load) ref_ptr = addr;
    end
    jtag_req = 1'b1; jtag_wr = wr; jtag_incr = incr; jtag_addr_load = load;
    jtag_addr = addr; jtag_wdata = wdata;
    tick();
    jtag_req = 1'b0; jtag_incr = 1'b0; jtag_addr_load = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, jtag_busy, 1'b1);
    while (!mon_ready && cyc < 40) begin tick(); cyc++; end
    check({tag, "_lat"}, cyc, wr ? 3 : 4);
    if (wr) ref_mem[a] = wdata;
    else    check({tag, "_data"}, mon_dreg, ref_mem[a]);
  endtask

  task automatic load_ptr(input logic [7:0] addr);
    jtag_addr_load = 1'b1; jtag_addr = addr;
    tick();
    jtag_addr_load = 1'b0;
    ref_ptr = addr;
  endtask

  task automatic wait_ready(input string tag);
    int cyc;
    cyc = 0;
    while (!mon_ready && cyc < 20) begin tick(); cyc++; end
    check(tag, mon_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wait"},  avs_waitrequest, 1'b0);
    check({tag, "_rdata"}, avs_readdata, 32'h0);
    check({tag, "_we"},    ram_we, 1'b0);
    check({tag, "_rdy"},   mon_ready, 1'b0);
    check({tag, "_dreg"},  mon_dreg, 32'h0);
    check({tag, "_busy"},  jtag_busy, 1'b0);
    check({tag, "_ovr"},   jtag_overrun, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int q_seq[$];
    int cpu_done, jtag_iss, jtag_done, cpu_t0, cyc;
    logic [7:0]  a;
    logic [31:0] d;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // CPU write then read back
    do_cpu("cpu_wr10", 1'b1, 8'h10, 32'hDEADBEEF);
    do_cpu("cpu_rd10", 1'b0, 8'h10, 32'h0);

    // JTAG direct read
    do_cpu("pre20", 1'b1, 8'h20, 32'h12345678);
    do_jtag("jrd20", 1'b0, 1'b0, 1'b0, 8'h20, 32'h0);

    // Pointer wrap through 0xFF -> 0x00, ending at 0x01
    do_cpu("preFE", 1'b1, 8'hFE, 32'hCAFE00FE);
    do_cpu("preFF", 1'b1, 8'hFF, 32'hCAFE00FF);
    do_cpu("pre00", 1'b1, 8'h00, 32'hCAFE0000);
    do_cpu("pre01", 1'b1, 8'h01, 32'hCAFE0001);
    load_ptr(8'hFE);
    do_jtag("inc_fe", 1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    do_jtag("inc_ff", 1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    do_jtag("inc_00", 1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    do_jtag("inc_01", 1'b0, 1'b1, 1'b0, 8'h00, 32'h0);

    // Load and incr in the same cycle
    do_cpu("pre11", 1'b1, 8'h11, 32'h01234511);
    do_jtag("ldinc10", 1'b0, 1'b1, 1'b1, 8'h10, 32'h0);
    do_jtag("ldinc11", 1'b0, 1'b1, 1'b0, 8'h00, 32'h0);

    // Overrun: drop while full, accept on the clearing cycle
    do_cpu("pre30", 1'b1, 8'h30, 32'h0BADF00D);
    jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h30;
    tick();
    check("ovr_busy", jtag_busy, 1'b1);
    jtag_wr = 1'b1; jtag_addr = 8'h31; jtag_wdata = 32'hDEAD0031;
    tick();
    check("ovr_set", jtag_overrun, 1'b1);
    jtag_req = 1'b0; jtag_ovr_clr = 1'b1;
    tick();
    jtag_ovr_clr = 1'b0;
    check("ovr_clr", jtag_overrun, 1'b0);
    check("ovr_rdy_early", mon_ready, 1'b0);
    jtag_req = 1'b1; jtag_wr = 1'b1; jtag_addr = 8'h31; jtag_wdata = 32'hA5A50031;
    tick();
    jtag_req = 1'b0;
    check("ovr_rdy", mon_ready, 1'b1);
    check("ovr_dreg", mon_dreg, ref_mem[8'h30]);
    check("ovr_accept_busy", jtag_busy, 1'b1);
    check("ovr_accept_noovr", jtag_overrun, 1'b0);
    ref_mem[8'h31] = 32'hA5A50031;
    tick();
    wait_ready("ovr_wr_done");
    tick();
    do_cpu("ovr_rd31", 1'b0, 8'h31, 32'h0);

    // Set beats clear in the same cycle
    jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h30;
    tick();
    jtag_ovr_clr = 1'b1;
    tick();
    jtag_req = 1'b0; jtag_ovr_clr = 1'b0;
    check("ovr_set_wins", jtag_overrun, 1'b1);
    jtag_ovr_clr = 1'b1;
    tick();
    jtag_ovr_clr = 1'b0;
    check("ovr_clr2", jtag_overrun, 1'b0);
    wait_ready("ovr_rd_done");
    check("ovr_rd_dreg", mon_dreg, ref_mem[8'h30]);
    tick();

    // Fairness: CPU read held while JTAG writes as soon as it is free
    do_cpu("pre50", 1'b1, 8'h50, 32'h55AA0050);
    cpu_done = 0; jtag_iss = 0; jtag_done = 0; cpu_t0 = 0;
    avs_address = 8'h50; avs_read = 1'b1; avs_write = 1'b0;
    for (int c = 0; c < 60 && cpu_done < 4; c++) begin
      if (mon_ready) begin q_seq.push_back(1); jtag_done++; end
      if (!jtag_busy && jtag_iss < 4) begin
        a = 8'(8'h60 + jtag_iss);
        d = 32'hF00D0000 + 32'(jtag_iss);
        jtag_req = 1'b1; jtag_wr = 1'b1; jtag_incr = 1'b0; jtag_addr = a; jtag_wdata = d;
        ref_mem[a] = d;
        jtag_iss++;
      end
      #1;
      if (!avs_waitrequest) begin
        q_seq.push_back(0);
        cpu_done++;
        check("fair_cpu_lat_le6", 32'((c - cpu_t0 + 1) <= 6), 1);
        check("fair_cpu_data", avs_readdata, ref_mem[8'h50]);
        cpu_t0 = c + 1;
      end
      tick();
      jtag_req = 1'b0;
    end
    avs_read = 1'b0;
    check("fair_cpu_done", cpu_done, 4);
    check("fair_jtag_done", 32'(jtag_done >= 3), 1);
    for (int i = 1; i < q_seq.size(); i++)
      check("fair_alternate", 32'(q_seq[i] != q_seq[i-1]), 1);
    check("fair_no_ovr", jtag_overrun, 1'b0);
    cyc = 0;
    while ((jtag_busy || !mon_ready) && cyc < 20) begin tick(); cyc++; end
    check("fair_drain", mon_ready, 1'b1);
    tick();
    do_cpu("fair_rd60", 1'b0, 8'h60, 32'h0);
    do_cpu("fair_rd63", 1'b0, 8'h63, 32'h0);

    // Async reset during CPU_RDATA with a JTAG read pending
    avs_address = 8'h10; avs_read = 1'b1;
    jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h20;
    tick();
    jtag_req = 1'b0;
    tick();
    #1;
    check("rst_in_rdata", avs_waitrequest, 1'b0);
    reset_n = 1'b0; avs_read = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    reset_n = 1'b1;
    ref_ptr = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_ready", mon_ready, 1'b0);
    end

    // Randomized accesses against the reference model
    for (int n = 0; n < 80; n++) begin
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      case ($urandom_range(0, 5))
        0: do_cpu("rnd_cpu_wr", 1'b1, a, d);
        1: do_cpu("rnd_cpu_rd", 1'b0, a, 32'h0);
        2: do_jtag("rnd_j_wr", 1'b1, 1'b0, 1'b0, a, d);
        3: do_jtag("rnd_j_rd", 1'b0, 1'b0, 1'($urandom_range(0, 3) == 0), a, 32'h0);
        4: do_jtag("rnd_j_rdinc", 1'b0, 1'b1, 1'($urandom_range(0, 3) == 0), a, 32'h0);
        default: do_jtag("rnd_j_wrinc", 1'b1, 1'b1, 1'($urandom_range(0, 3) == 0), a, d);
      endcase
    end
    check("rnd_no_ovr", jtag_overrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lab3_qsys_debug_ocimem_arbiter.md
# lab3_qsys_debug_ocimem_arbiter

Arbiter that shares the Nios II on-chip debug monitor RAM (single-port, 1-cycle read latency) between two requesters: the JTAG debug path, which issues single-cycle, non-stallable access pulses decoded from the debug-slave take-action strobes and `jdo`, and the CPU-side Avalon-MM debug slave port, which is stalled with `waitrequest`. It sits between the debug-slave wrapper's sysclk outputs and the monitor RAM. It returns JTAG read data as `mon_dreg` plus a `mon_ready` pulse. Internal state: a JTAG holding register and an auto-increment address pointer.

## Interface
- ADDR_W, 8, monitor RAM word-address width
- DATA_W, 32, data width
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- jtag_req  in  1  one-cycle JTAG access pulse
- jtag_wr  in  1  with jtag_req: 1 = write, 0 = read
- jtag_incr  in  1  with jtag_req: use pointer address, then post-increment pointer
- jtag_addr_load  in  1  load pointer from jtag_addr
- jtag_addr  in  ADDR_W  direct address / pointer load value
- jtag_wdata  in  DATA_W  JTAG write data
- jtag_ovr_clr  in  1  clears jtag_overrun
- mon_dreg  out  DATA_W  last JTAG read data
- mon_ready  out  1  one-cycle completion pulse per JTAG access
- jtag_busy  out  1  holding register full
- jtag_overrun  out  1  sticky: jtag_req dropped
- avs_address  in  ADDR_W  CPU address, stable while stalled
- avs_read, avs_write  in  1  CPU request; never both high
- avs_writedata  in  DATA_W  CPU write data
- avs_readdata  out  DATA_W  CPU read data
- avs_waitrequest  out  1  CPU stall
- ram_addr  out  ADDR_W  monitor RAM address
- ram_we  out  1  monitor RAM write enable
- ram_wdata  out  DATA_W  monitor RAM write data
- ram_rdata  in  DATA_W  RAM data for the address presented on the previous cycle

## Operation
- JTAG capture on jtag_req:
  - If the holding register is empty, or is being cleared this same cycle: latch wr, wdata, and address (jtag_incr ? pointer : jtag_addr); set pend.
  - Otherwise: drop the request and set jtag_overrun.
- Overrun flag: jtag_ovr_clr clears it; a set in the same cycle wins.
- Pointer:
  - jtag_addr_load loads jtag_addr.
  - A captured incr request post-increments the pointer modulo 2^ADDR_W (0xFF wraps to 0x00).
  - Load and incr request in the same cycle: the access uses jtag_addr; pointer becomes jtag_addr+1.
- FSM states: IDLE, CPU_ACC, CPU_RDATA, JTAG_ACC, JTAG_RDATA.
  - IDLE:
    - pend and CPU requesting: grant the side not served last (last_grant bit).
    - Otherwise pend → JTAG_ACC; avs_read|avs_write → CPU_ACC.
    - waitrequest=1 whenever a CPU request is present.
  - CPU_ACC: ram_addr=avs_address, ram_we=avs_write, ram_wdata=avs_writedata.
    - Write: waitrequest=0 → IDLE.
    - Read: waitrequest=1 → CPU_RDATA.
  - CPU_RDATA: avs_readdata=ram_rdata, waitrequest=0 → IDLE.
  - JTAG_ACC: RAM driven from the holding register.
    - Write: clear pend, pulse mon_ready next cycle → IDLE.
    - Read: → JTAG_RDATA.
  - JTAG_RDATA: mon_dreg ← ram_rdata, clear pend, pulse mon_ready next cycle → IDLE.
- ram_we is 0 outside the *_ACC states.
- jtag_busy = pend.

## Timing
- Reset values:
  - State IDLE; pend, pointer, last_grant, jtag_overrun, mon_ready, mon_dreg, avs_readdata all 0.
  - ram_we=0; avs_waitrequest follows IDLE rule.
- CPU latency:
  - Write: 2 cycles (request cycle stalled, completes in CPU_ACC).
  - Read: 3 cycles, without contention.
  - Each JTAG access ahead of it adds 2 (write) or 3 (read) cycles.
- JTAG latency:
  - jtag_req at cycle 0 → pend at cycle 1 → JTAG_ACC at cycle 2.
  - Write: mon_ready at cycle 3.
  - Read: JTAG_RDATA at cycle 3, mon_ready and mon_dreg valid at cycle 4.
- Fairness: at most one JTAG access between consecutive CPU accesses while the CPU is waiting, and vice versa.
- Async reset mid-access aborts it:
  - In-flight write may or may not reach RAM.
  - No mon_ready pulse, no readdata.

## Structure
- Shared package: FSM state enum, default ADDR_W/DATA_W constants.
- One natural sub-module: lab3_qsys_debug_jtag_holdreg (capture, pend, overrun, pointer).
- Arbiter FSM and RAM mux in the top module.

## Test plan
- CPU write 0xDEADBEEF @0x10, then read @0x10 → waitrequest low on cycle 2 (write) and cycle 3 (read); readdata 0xDEADBEEF.
- jtag_addr_load 0xFE, then three incr reads → RAM addresses 0xFE, 0xFF, 0x00; three mon_ready pulses; pointer ends at 0x01.
- JTAG read @0x20 (RAM holds 0x12345678) → mon_ready at cycle 4, mon_dreg 0x12345678.
- CPU read held continuously while JTAG issues back-to-back writes every 3 cycles → grants alternate JTAG/CPU; CPU completes within 6 cycles.
- Second jtag_req while pend=1 and not clearing → dropped, jtag_overrun=1 until jtag_ovr_clr; a jtag_req on the same cycle pend clears is accepted.
- reset_n low during CPU_RDATA → next cycle IDLE, all outputs at reset values, no mon_ready.
